// File: rtl/stream_selector.sv
`default_nettype none
// ============================================================================
// Module   : stream_selector
// Brief    : Registered N-channel valid/ready selector, fixed or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module stream_selector #(
    parameter  int bitWidth = 4,
    parameter  int channels = 4,
    localparam int selWidth = (channels > 1) ? $clog2(channels) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [channels*bitWidth-1:0] in_data,
    input  logic [channels-1:0]          in_valid,
    output logic [channels-1:0]          in_ready,
    input  logic                         mode,
    input  logic [selWidth-1:0]          SEL,
    output logic [bitWidth-1:0]          out_data,
    output logic [selWidth-1:0]          out_channel,
    output logic                         out_valid,
    input  logic                         out_ready
);

    logic [bitWidth-1:0] r_out_data;
    logic [selWidth-1:0] r_out_channel;
    logic                r_out_valid;
    logic [selWidth-1:0] r_ptr;

    logic                w_can_accept;
    logic                w_grant_found;
    logic [selWidth-1:0] w_grant_idx;
    logic                w_xfer;
    logic [bitWidth-1:0] w_sel_data;
    logic [selWidth-1:0] w_ptr_next;

    assign w_can_accept = !r_out_valid || out_ready;

    // Grant search. Round-robin walks ptr, ptr+1, ... modulo channels; the
    // inner loop matches on a constant index so no variable bit-select is needed.
    always_comb begin
        int idx;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        idx           = 0;
        if (!mode) begin
            for (int i = 0; i < channels; i++) begin
                if ((SEL == selWidth'(i)) && in_valid[i]) begin
                    w_grant_found = 1'b1;
                    w_grant_idx   = selWidth'(i);
                end
            end
        end else begin
            for (int k = 0; k < channels; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= channels) begin
                    idx = idx - channels;
                end
                for (int i = 0; i < channels; i++) begin
                    if (!w_grant_found && (i == idx) && in_valid[i]) begin
                        w_grant_found = 1'b1;
                        w_grant_idx   = selWidth'(i);
                    end
                end
            end
        end
    end

    assign w_xfer = w_grant_found && w_can_accept && !rst;

    always_comb begin
        w_sel_data = '0;
        in_ready   = '0;
        for (int i = 0; i < channels; i++) begin
            if (w_grant_idx == selWidth'(i)) begin
                w_sel_data  = in_data[i*bitWidth +: bitWidth];
                in_ready[i] = w_xfer;
            end
        end
    end

    always_comb begin
        if (int'(w_grant_idx) == channels - 1) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_grant_idx + selWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data    <= '0;
            r_out_channel <= '0;
            r_out_valid   <= 1'b0;
            r_ptr         <= '0;
        end else if (w_xfer) begin
            r_out_data    <= w_sel_data;
            r_out_channel <= w_grant_idx;
            r_out_valid   <= 1'b1;
            if (mode) begin
                r_ptr <= w_ptr_next;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data    = r_out_data;
    assign out_channel = r_out_channel;
    assign out_valid   = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_selector
// Brief    : Self-checking bench for stream_selector against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_selector;

    localparam int BW = 4;
    localparam int CH = 4;

    logic            clk;
    logic            rst;
    logic [CH*BW-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            mode;
    logic [1:0]      sel;
    logic [BW-1:0]   out_data;
    logic [1:0]      out_channel;
    logic            out_valid;
    logic            out_ready;

    // three-channel instance for the out-of-range select case
    logic [3*BW-1:0] in_data3;
    logic [2:0]      in_valid3;
    logic [2:0]      in_ready3;
    logic            mode3;
    logic [1:0]      sel3;
    logic [BW-1:0]   out_data3;
    logic [1:0]      out_channel3;
    logic            out_valid3;
    logic            out_ready3;

    int total = 0;
    int bad   = 0;

    // model state
    int          m_ptr;
    logic        m_valid;
    logic [BW-1:0] m_data;
    logic [1:0]  m_chan;

    stream_selector #(.bitWidth(BW), .channels(CH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .SEL(sel), .out_data(out_data),
        .out_channel(out_channel), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_selector #(.bitWidth(BW), .channels(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .SEL(sel3), .out_data(out_data3),
        .out_channel(out_channel3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CH-1:0] model_ready(input logic md, input logic [1:0] s,
                                                  input logic [CH-1:0] v, input logic ordy);
        logic [CH-1:0] r;
        int g;
        int idx;
        r = '0;
        g = -1;
        if (!md) begin
            if (int'(s) < CH && v[s]) g = int'(s);
        end else begin
            for (int k = 0; k < CH; k++) begin
                idx = (m_ptr + k) % CH;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0 && (!m_valid || ordy)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_chan = '0;
    endtask

    // One clock edge; the model advances using inputs sampled before the edge.
    task automatic tick();
        logic [CH-1:0]    r;
        logic [CH*BW-1:0] d;
        logic             md;
        logic             ordy;
        r = model_ready(mode, sel, in_valid, out_ready);
        d = in_data; md = mode; ordy = out_ready;
        @(posedge clk);
        #1;
        if (r != '0) begin
            for (int i = 0; i < CH; i++) begin
                if (r[i]) begin
                    m_data  = d[i*BW +: BW];
                    m_chan  = i[1:0];
                    m_valid = 1'b1;
                    if (md) m_ptr = (i + 1) % CH;
                end
            end
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = '1; in_data = 16'h4321; out_ready = 1'b0;
        in_valid3 = '1; in_data3 = '0; mode3 = 1'b0; sel3 = 2'd3; out_ready3 = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 4'h0 || out_channel !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got ready=%b valid=%b data=%h chan=%0d exp 0000/0/0/0",
                     in_ready, out_valid, out_data, out_channel);
        end
        rst = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'h1) begin
            bad++;
            $display("FAIL reset_preload got valid=%b data=%h exp 1/1", out_valid, out_data);
        end
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset got valid=%b data=%h ready=%b exp 0/0/0000",
                     out_valid, out_data, in_ready);
        end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_data = 16'hDCBA; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin
            bad++;
            $display("FAIL fixed_ready got=%b exp=0100", in_ready);
        end
        tick();
        total++;
        if (out_data !== 4'hC || out_channel !== 2'd2 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL fixed_out got data=%h chan=%0d valid=%b exp C/2/1",
                     out_data, out_channel, out_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            total++;
            if (int'(out_channel) != exp_seq[n] || out_valid !== 1'b1 || out_data !== m_data) begin
                bad++;
                $display("FAIL rr_seq[%0d] got chan=%0d data=%h valid=%b exp chan=%0d data=%h valid=1",
                         n, out_channel, out_data, out_valid, exp_seq[n], m_data);
            end
        end
    endtask

    task automatic test_sparse();
        int exp_seq[4] = '{0, 3, 0, 1};
        logic [CH-1:0] vseq[4] = '{4'b0001, 4'b1001, 4'b1001, 4'b1111};
        mode = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in_valid = vseq[n];
            tick();
            total++;
            if (int'(out_channel) != exp_seq[n]) begin
                bad++;
                $display("FAIL sparse[%0d] got chan=%0d exp=%0d", n, out_channel, exp_seq[n]);
            end
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 16'h0005; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_data = 16'h0007;
        for (int n = 0; n < 3; n++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL stall_ready[%0d] got=%b exp=0000", n, in_ready);
            end
            tick();
            total++;
            if (out_data !== 4'h5 || out_valid !== 1'b1 || out_channel !== 2'd0) begin
                bad++;
                $display("FAIL stall_hold[%0d] got data=%h valid=%b chan=%0d exp 5/1/0",
                         n, out_data, out_valid, out_channel);
            end
        end
        out_ready = 1'b1; in_data = 16'h0006;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL release_ready got=%b exp=0001", in_ready);
        end
        tick();
        total++;
        if (out_data !== 4'h6 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL release_load got data=%h valid=%b exp 6/1", out_data, out_valid);
        end
    endtask

    task automatic test_unselected();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b1101; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL unsel_ready got=%b exp=0000", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 4'h6) begin
            bad++;
            $display("FAIL unsel_drain got valid=%b data=%h exp 0/6", out_valid, out_data);
        end
        mode3 = 1'b0; sel3 = 2'd3; out_ready3 = 1'b1;
        for (int n = 0; n < 8; n++) begin
            in_valid3 = 3'($urandom) | 3'b001;
            in_data3  = 12'($urandom);
            #1;
            total++;
            if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
                bad++;
                $display("FAIL oor_sel[%0d] got ready=%b valid=%b exp 000/0", n, in_ready3, out_valid3);
            end
            tick();
        end
    endtask

    task automatic test_mode_switch();
        int exp_seq[5] = '{0, 1, 0, 0, 2};
        logic mseq[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1; #1; rst = 1'b0; model_reset();
        sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1; in_data = 16'h3210;
        for (int n = 0; n < 5; n++) begin
            mode = mseq[n];
            tick();
            total++;
            if (int'(out_channel) != exp_seq[n] || out_data !== 4'(exp_seq[n])) begin
                bad++;
                $display("FAIL mode_switch[%0d] got chan=%0d data=%h exp=%0d",
                         n, out_channel, out_data, exp_seq[n]);
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] exp_r;
        for (int n = 0; n < 400; n++) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid3 = 3'($urandom);
            out_ready3 = 1'($urandom);
            #1;
            exp_r = model_ready(mode, sel, in_valid, out_ready);
            total++;
            if (in_ready !== exp_r || in_ready3 !== 3'b000) begin
                bad++;
                $display("FAIL rand_ready[%0d] got=%b exp=%b ready3=%b", n, in_ready, exp_r, in_ready3);
            end
            tick();
            total++;
            if (out_valid !== m_valid || out_data !== m_data || out_channel !== m_chan) begin
                bad++;
                $display("FAIL rand_out[%0d] got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
                         n, out_valid, out_data, out_channel, m_valid, m_data, m_chan);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_unselected();
        test_mode_switch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_selector.md
# stream_selector

Parametrised, registered N-channel data selector with valid/ready handshaking on every input and on the output. Each cycle it picks one input channel, either by an explicit select or by round-robin arbitration, and latches that channel's word into a single-entry output register. It sits between the CPU's data sources (registers, input port, immediate) and downstream consumers that can stall, such as the ALU operand stage or the output port.

## Interface

Parameters:
- bitWidth, 4, width of each data word.
- channels, 4, number of input channels; legal range 2–16.
- selWidth, derived as clog2(channels) (minimum 1); local, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_data  input  channels*bitWidth  packed inputs; channel i occupies bits [i*bitWidth +: bitWidth].
- in_valid  input  channels  per-channel valid.
- in_ready  output  channels  per-channel ready; at most one bit set (one-hot or zero).
- mode  input  1  0 = fixed select, 1 = round-robin.
- SEL  input  selWidth  channel index used in fixed mode.
- out_data  output  bitWidth  registered selected word.
- out_channel  output  selWidth  index of the channel that produced out_data.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.

## Operation

- Output register: a single entry holding out_data, out_channel and out_valid.
- can_accept = !out_valid || out_ready.
- Grant is combinational from the current inputs and state.
  - Fixed mode: grant SEL when SEL < channels and in_valid[SEL] = 1; otherwise no grant. Other channels never see ready.
  - Round-robin mode: search channels ptr, ptr+1, …, wrapping modulo channels. Grant the first channel whose in_valid is 1.
- in_ready[g] = can_accept for the granted channel g. All other bits are 0. With no grant, in_ready = 0.
- Transfer: in_valid[g] && in_ready[g]. On a transfer, at the next edge:
  - out_data ← in_data[g]
  - out_channel ← g
  - out_valid ← 1
- Drain without a new transfer (out_valid && out_ready, no grant): out_valid ← 0. out_data and out_channel keep their last values.
- Simultaneous drain and transfer: the register is overwritten with the new word and out_valid stays 1. Full throughput is one word per cycle.
- Stall (out_valid && !out_ready): out_data and out_channel are held stable, and all in_ready bits are 0.
- ptr (selWidth bits) updates only on a round-robin transfer: ptr ← g+1, wrapping to 0 when g = channels-1. Fixed-mode transfers leave ptr unchanged.
- Changing mode or SEL takes effect in the same cycle's grant computation. No transfer is lost or duplicated.
- Non-power-of-two channels: ptr never reaches a value ≥ channels. In fixed mode, an out-of-range SEL produces no grant.

## Timing

- Reset values: out_valid = 0, out_data = 0, out_channel = 0, ptr = 0. in_ready is 0 while rst is high.
- Reset asserted mid-operation: the pending output word is discarded immediately (asynchronously). Upstream words not yet transferred are unaffected.
- Latency: a word transferred in cycle n appears on out_data, with out_valid = 1, in cycle n+1.
- Combinational paths:
  - in_valid, mode, SEL and out_ready → in_ready.
  - No combinational path from any input to out_data, out_valid or out_channel.
- Handshake rule: once out_valid is asserted, out_data and out_channel stay stable until the cycle in which out_ready = 1.

## Test plan

1. Reset and fixed select (bitWidth=4, channels=4): assert rst with out_valid = 1 pending -> out_valid drops to 0 without a clock edge; out_data = 0. Then mode = 0, SEL = 2, in_data = {D=4'hD, C=4'hC, B=4'hB, A=4'hA}, all valid, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 4'hC and out_channel = 2.
2. Round-robin fairness: mode = 1, all four valid, out_ready = 1 for 6 cycles -> out_channel sequence 0,1,2,3,0,1 and ptr wraps 3→0.
3. Sparse requests: mode = 1, ptr = 1, only channels 0 and 3 valid -> grant 3 first, then 0, and ptr = 1 afterwards.
4. Backpressure: out_valid = 1 with out_data = 4'h5 and out_ready = 0 for 3 cycles -> in_ready = 0 and out_data holds 4'h5. In the cycle out_ready = 1 with a valid request, the new word loads, out_valid stays 1 and no bubble appears.
5. Fixed mode with unselected or out-of-range channel: mode = 0, SEL = 1, in_valid = 4'b1101 -> no grant and out_valid goes to 0 after draining. Separately, channels = 3 with SEL = 3 -> no grant ever.
6. Mode switch: mode = 1, two grants (ptr = 2), switch to mode = 0 with SEL = 0 for two transfers, then switch back -> round-robin resumes at channel 2.
